// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 byte receive stage.
//   state_t                 receive FSM states (IDLE, DATA, PARITY, STOP, DONE)
//   ERR_PARITY / ERR_STOP   bit positions inside BYTE_ERROR_CODE
//   DEFAULT_TIMEOUT_CYCLES  inter-edge timeout (500 us at 100 MHz)
//   DEFAULT_FILTER_LEN      stability length of the optional glitch filter
//   parity_error()          odd-parity check over data plus parity bit
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;
  localparam int DEFAULT_FILTER_LEN     = 8;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic parity_error(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/ps2_byte_receiver_if.sv
// ps2_byte_receiver_if: consumer-side bundle of the PS/2 byte receiver.
//   READ_ENABLE      consumer -> receiver, permits reception
//   BYTE_READ[7:0]   last received byte, held until the next completed frame
//   BYTE_READY       one-cycle strobe, a frame has completed
//   BYTE_ERROR_CODE  {stop error, parity error}, valid with BYTE_READY, held after
//   TIMEOUT          one-cycle strobe, a frame was aborted by the inter-edge timeout
//
// Handshake: BYTE_READY is a valid-only strobe with no backpressure. The byte
// and error code are valid in the cycle BYTE_READY is high and stay stable
// until the next strobe. READ_ENABLE acts as the only flow control: while it
// is low no new frame starts and any frame in flight is abandoned silently.
interface ps2_byte_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic       BYTE_READY;
  logic [1:0] BYTE_ERROR_CODE;
  logic       TIMEOUT;

  modport master (
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_READY,
    output BYTE_ERROR_CODE,
    output TIMEOUT
  );

  modport slave (
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_READY,
    input  BYTE_ERROR_CODE,
    input  TIMEOUT
  );
endinterface

// File: rtl/ps2_line_conditioner.sv
// ps2_line_conditioner: conditions one raw PS/2 line.
//   CLK, RESET  system clock, synchronous active-high reset
//   LINE_IN     raw asynchronous line
//   LINE_OUT    conditioned level
//   FALL        one-cycle high when LINE_OUT went 1 -> 0
// A 2-FF synchroniser always precedes the edge detector. With the macro
// PS2_GLITCH_FILTER_EN defined, a stability filter sits between them: the
// conditioned level only follows the synchroniser after FILTER_LEN
// consecutive identical samples, delaying the line by FILTER_LEN cycles.
// All state resets to 1 because both PS/2 lines idle high, so leaving reset
// never fakes a falling edge.
module ps2_line_conditioner #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic LINE_IN,
  output logic LINE_OUT,
  output logic FALL
);

`ifdef PS2_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic sync_q1;
  logic sync_q2;
  logic cond;
  logic prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= LINE_IN;
      sync_q2 <= sync_q1;
    end
  end

  if (FILTER_ON && FILTER_LEN >= 1) begin : g_filter
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts how many consecutive samples have disagreed with filt_q;
    // any agreeing sample restarts the count, so short pulses vanish.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else if (sync_q2 == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= sync_q2;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign cond = filt_q;
  end else begin : g_bypass
    assign cond = sync_q2;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= cond;
    end
  end

  assign LINE_OUT = cond;
  assign FALL     = prev_q & ~cond;

endmodule

// File: rtl/ps2_byte_receiver.sv
// ps2_byte_receiver: byte-level PS/2 device-to-host receive stage.
//   CLK            system clock (100 MHz)
//   RESET          synchronous active-high reset
//   CLK_MOUSE_IN   raw PS/2 clock line
//   DATA_MOUSE_IN  raw PS/2 data line
//   bus            consumer bundle (READ_ENABLE in; BYTE_READ, BYTE_READY,
//                  BYTE_ERROR_CODE, TIMEOUT out)
//   DEBUG_STATE    current receive FSM state
// Frames are 11 bits sampled on PS/2 clock falling edges: start (0), eight
// data bits LSB first, odd parity, stop (1). Parity and stop errors are
// flagged but the byte is still delivered. A frame that stalls for
// TIMEOUT_CYCLES between falling edges is abandoned with a TIMEOUT strobe.
// Optional macro PS2_GLITCH_FILTER_EN adds a FILTER_LEN stability filter to
// both lines (see ps2_line_conditioner).
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CLK_MOUSE_IN,
  input  logic                       DATA_MOUSE_IN,
  ps2_byte_receiver_if.master        bus,
  output state_t                     DEBUG_STATE
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic clk_fall;
  logic clk_level_unused;
  logic data_s;
  logic data_fall_unused;

  ps2_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_clk_cond (
    .CLK      (CLK),
    .RESET    (RESET),
    .LINE_IN  (CLK_MOUSE_IN),
    .LINE_OUT (clk_level_unused),
    .FALL     (clk_fall)
  );

  ps2_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_data_cond (
    .CLK      (CLK),
    .RESET    (RESET),
    .LINE_IN  (DATA_MOUSE_IN),
    .LINE_OUT (data_s),
    .FALL     (data_fall_unused)
  );

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    byte_q;
  logic [1:0]    err_q;
  logic          timeout_q;
  logic          timeout_hit;
  logic          re;

  assign re = bus.READ_ENABLE;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Inside a frame the priority is: READ_ENABLE abort,
  // then a falling edge (so an edge arriving on the timeout cycle still
  // counts), then the timeout.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clk_fall && re && !data_s) state_d = DATA;
      end
      DATA, PARITY, STOP: begin
        if (!re) begin
          state_d = IDLE;
        end else if (clk_fall) begin
          if (state_q == DATA)        state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
          else if (state_q == PARITY) state_d = STOP;
          else                        state_d = DONE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, counters and the held result registers.
  // Result registers load on the STOP edge so they are already valid in the
  // DONE cycle alongside BYTE_READY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tcnt_q    <= '0;
      byte_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;

      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
      end else if (state_q == DATA && clk_fall) begin
        shift_q[bit_cnt_q] <= data_s;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end

      if (state_q == PARITY && clk_fall) parity_q <= data_s;

      if (state_q == STOP && state_d == DONE) begin
        byte_q             <= shift_q;
        err_q[ERR_PARITY]  <= parity_error(shift_q, parity_q);
        err_q[ERR_STOP]    <= ~data_s;
      end

      if ((state_q == DATA || state_q == PARITY || state_q == STOP) && !clk_fall) begin
        tcnt_q <= tcnt_q + TW'(1);
      end else begin
        tcnt_q <= '0;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.BYTE_READY      = (state_q == DONE);
    bus.BYTE_READ       = byte_q;
    bus.BYTE_ERROR_CODE = err_q;
    bus.TIMEOUT         = timeout_q;
    DEBUG_STATE         = state_q;
  end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// tb_ps2_byte_receiver: directed frames against a frame-level model.
// The model predicts each delivered byte and its error code from the frame
// contents ($countones for parity), holds the last delivered byte, and
// expects timeout strobes only where a frame is stalled.
module tb_ps2_byte_receiver;
  import ps2_pkg::*;

  localparam int TB_TIMEOUT = 300;
  localparam int TB_FILTER  = 8;
  localparam int HALF       = 20;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int COND_LAT = 3 + TB_FILTER;
`else
  localparam int COND_LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic   CLK           = 1'b0;
  logic   RESET         = 1'b1;
  logic   CLK_MOUSE_IN  = 1'b1;
  logic   DATA_MOUSE_IN = 1'b1;
  state_t dbg_state;

  ps2_byte_receiver_if bus ();

  ps2_byte_receiver #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .FILTER_LEN     (TB_FILTER)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .CLK_MOUSE_IN  (CLK_MOUSE_IN),
    .DATA_MOUSE_IN (DATA_MOUSE_IN),
    .bus           (bus),
    .DEBUG_STATE   (dbg_state)
  );

  always #5 CLK = ~CLK;

  int   cycle_cnt = 0;
  logic rst_d     = 1'b0;

  always @(posedge CLK) begin
    cycle_cnt <= cycle_cnt + 1;
    rst_d     <= RESET;
  end

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];       // {error_code, byte}
  int         exp_timeouts   = 0;
  int         n_checks       = 0;
  int         n_pass         = 0;
  int         ready_seen     = 0;
  int         timeout_seen   = 0;
  int         last_fall_cycle = 0;
  logic       started        = 1'b0;
  logic [7:0] model_byte     = 8'h00;
  logic [1:0] model_err      = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (started) begin
      if (rst_d) begin
        model_byte = 8'h00;
        model_err  = 2'b00;
        check("reset_ready", bus.BYTE_READY, 1'b0);
        check("reset_timeout", bus.TIMEOUT, 1'b0);
        check("reset_state", dbg_state, IDLE);
      end else begin
        if (bus.BYTE_READY) begin
          logic [9:0] e;
          ready_seen++;
          check("ready_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            model_byte = e[7:0];
            model_err  = e[9:8];
            check("ready_latency", cycle_cnt - last_fall_cycle, COND_LAT);
          end
        end
        if (bus.TIMEOUT) begin
          timeout_seen++;
          check("timeout_expected", exp_timeouts > 0, 1'b1);
          if (exp_timeouts > 0) exp_timeouts--;
          check("timeout_window",
                (cycle_cnt - last_fall_cycle >= TB_TIMEOUT) &&
                (cycle_cnt - last_fall_cycle <= TB_TIMEOUT + COND_LAT + 3), 1'b1);
        end
      end
      check("byte_read", bus.BYTE_READ, model_byte);
      check("error_code", bus.BYTE_ERROR_CODE, model_err);
    end
  end

  // ---------------- driver tasks ----------------
  // One PS/2 bit: data settles during the high phase, clock falls HALF
  // cycles later and rises again after another HALF cycles. With glitch set,
  // a 3-cycle low spike is injected on the clock mid high-phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge CLK);
    DATA_MOUSE_IN = b;
    if (glitch) begin
      repeat (10) @(negedge CLK);
      CLK_MOUSE_IN = 1'b0;
      repeat (3) @(negedge CLK);
      CLK_MOUSE_IN = 1'b1;
      repeat (HALF - 14) @(negedge CLK);
    end else begin
      repeat (HALF - 1) @(negedge CLK);
    end
    CLK_MOUSE_IN    = 1'b0;
    last_fall_cycle = cycle_cnt;
    repeat (HALF) @(negedge CLK);
    CLK_MOUSE_IN = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) ps2_bit(bits[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
    logic [10:0] bits;
    logic [1:0]  e;
    bits = make_frame(d, p, s);
    e[1] = ~s;
    e[0] = (($countones(d) + int'(p)) % 2) == 0;
    exp_q.push_back({e, d});
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], glitch);
    DATA_MOUSE_IN = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    DATA_MOUSE_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] bits;
    bus.READ_ENABLE = 1'b1;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    started = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("reset_byte_literal", bus.BYTE_READ, 8'h00);
    check("reset_err_literal", bus.BYTE_ERROR_CODE, 2'b00);
    idle(5);

    // clean 0xFA
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    check("fa_ok_byte", bus.BYTE_READ, 8'hFA);
    check("fa_ok_err", bus.BYTE_ERROR_CODE, 2'b00);
    check("fa_ok_count", ready_seen, 1);

    // parity error on 0xFA
    send_frame(8'hFA, 1'b0, 1'b1, 1'b0);
    check("fa_par_byte", bus.BYTE_READ, 8'hFA);
    check("fa_par_err", bus.BYTE_ERROR_CODE, 2'b01);
    check("fa_par_count", ready_seen, 2);

    // spurious start: a falling edge with data high in IDLE
    ps2_bit(1'b1, 1'b0);
    idle(10);
    check("spurious_count", ready_seen, 2);
    check("spurious_state", dbg_state, IDLE);

    // stop-bit error on 0x00
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("zero_stop_byte", bus.BYTE_READ, 8'h00);
    check("zero_stop_err", bus.BYTE_ERROR_CODE, 2'b10);

    // start + 4 data bits, then stall past the timeout
    exp_timeouts = 1;
    bits = make_frame(8'h3C, 1'b1, 1'b1);
    send_bits(bits, 0, 4);
    idle(TB_TIMEOUT + 60);
    check("timeout_count", timeout_seen, 1);
    check("timeout_no_ready", ready_seen, 3);
    check("timeout_byte_held", bus.BYTE_READ, 8'h00);
    check("timeout_state", dbg_state, IDLE);

    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    check("aa_byte", bus.BYTE_READ, 8'hAA);
    check("aa_err", bus.BYTE_ERROR_CODE, 2'b00);

    // READ_ENABLE dropped after data bit 3 of 0x55
    bits = make_frame(8'h55, 1'b1, 1'b1);
    send_bits(bits, 0, 4);
    bus.READ_ENABLE = 1'b0;
    send_bits(bits, 5, 10);
    idle(20);
    bus.READ_ENABLE = 1'b1;
    idle(5);
    check("re_drop_ready", ready_seen, 4);
    check("re_drop_timeout", timeout_seen, 1);
    check("re_drop_byte", bus.BYTE_READ, 8'hAA);

    // RESET in the middle of a frame
    bits = make_frame(8'h33, 1'b1, 1'b1);
    send_bits(bits, 0, 3);
    DATA_MOUSE_IN = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    idle(5);
    check("midreset_byte", bus.BYTE_READ, 8'h00);
    check("midreset_err", bus.BYTE_ERROR_CODE, 2'b00);
    check("midreset_state", dbg_state, IDLE);

    send_frame(8'h08, 1'b0, 1'b1, 1'b0);
    check("post_reset_byte", bus.BYTE_READ, 8'h08);
    check("post_reset_err", bus.BYTE_ERROR_CODE, 2'b00);

`ifdef PS2_GLITCH_FILTER_EN
    send_frame(8'hF4, 1'b0, 1'b1, 1'b1);
    check("glitch_byte", bus.BYTE_READ, 8'hF4);
    check("glitch_err", bus.BYTE_ERROR_CODE, 2'b00);
`endif

    idle(20);
    check("pending_bytes", exp_q.size(), 0);
    check("pending_timeouts", exp_timeouts, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, at time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ps2_byte_receiver.md
Name: ps2_byte_receiver

Overview:
- Byte-level PS/2 receive stage directly upstream of the mouse transceiver's master state machine.
- Conditions the raw mouse clock and data lines and deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop).
- Presents each byte to the consumer with a one-cycle strobe plus error flags.
- Enforces an inter-edge timeout so a stalled mouse cannot wedge the consumer.

Parameters:
- TIMEOUT_CYCLES, 50000, max CLK cycles between consecutive clock falling edges inside a frame (500 us at 100 MHz).
- FILTER_LEN, 8, consecutive identical synchronised samples required before a filtered line changes (used only with the optional feature).

Ports:
- CLK  input  1  system clock (100 MHz).
- RESET  input  1  synchronous, active-high reset.
- CLK_MOUSE_IN  input  1  raw PS/2 clock line (tristate input side).
- DATA_MOUSE_IN  input  1  raw PS/2 data line (tristate input side).
- READ_ENABLE  input  1  consumer permits reception; low aborts or blocks frames.
- BYTE_READ  output  8  last received byte; holds until next completed frame.
- BYTE_READY  output  1  one-cycle pulse when a frame completes.
- BYTE_ERROR_CODE  output  2  bit0 parity error, bit1 stop-bit error; valid with BYTE_READY, held after.
- TIMEOUT  output  1  one-cycle pulse on inter-edge timeout abort.

Behaviour:
- Reset values: BYTE_READ=0x00, BYTE_READY=0, BYTE_ERROR_CODE=2'b00, TIMEOUT=0. State is IDLE, bit counter is 0, timeout counter is 0.
- Line conditioning: both lines pass through a 2-FF synchroniser.
- Edge detection: a falling edge is detected when the conditioned clock was 1 last cycle and is 0 now. Data is sampled from the conditioned data line in that same cycle.
- State machine:
  - IDLE: on a falling edge with READ_ENABLE=1, if data=0 (start bit) go to DATA with count=0. If data=1, stay in IDLE; this is a spurious start and produces no output.
  - DATA: on each falling edge, shift the sample into bit[count] (LSB first). count increments; after count=7 go to PARITY.
  - PARITY: on a falling edge, latch the parity sample and go to STOP.
  - STOP: on a falling edge, go to DONE, computing:
    - parity_err = ~(^{data, parity_sample}) (odd parity required);
    - stop_err = ~sample.
  - DONE: single cycle. BYTE_READY=1, BYTE_READ and BYTE_ERROR_CODE are updated, then return to IDLE.
- Latency: BYTE_READY asserts exactly 1 cycle after the stop-bit edge-detect cycle.
- Bytes with parity or stop errors are still delivered; the consumer decides what to do with them.
- Timeout:
  - The counter runs in DATA, PARITY and STOP, and clears on every falling edge.
  - Reaching TIMEOUT_CYCLES forces IDLE with a one-cycle TIMEOUT pulse, no BYTE_READY, and BYTE_READ unchanged.
  - The counter is held at 0 in IDLE.
- READ_ENABLE low while not in IDLE: abort to IDLE next cycle, no strobes. If it falls in the DONE cycle, DONE still completes.
- Timeout and falling edge in the same cycle: the edge wins and the counter clears.
- RESET mid-frame returns to the reset state immediately. A partial frame is discarded; the next start bit is accepted normally.

Optional Feature:
- PS2_GLITCH_FILTER_EN defined: after the synchronisers, each line passes through a stability filter. The filtered output changes only after FILTER_LEN consecutive identical samples, which adds FILTER_LEN cycles of latency to both lines equally.
- Undefined: synchroniser outputs feed the edge detector directly, and pulses shorter than FILTER_LEN are not suppressed.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP, DONE);
  - error bit indices ERR_PARITY=0, ERR_STOP=1;
  - the default timeout constant.
- Sub-module ps2_line_conditioner provides the synchroniser and optional filter. It is instantiated once per line, with a falling-edge output used on the clock instance only.

Test Plan:
- Frame 0xFA, parity 1, stop 1, 12 kHz PS/2 clock -> one BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=00.
- Frame 0xFA with parity bit 0 -> BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=01.
- Frame 0x00, parity 1, stop bit 0 -> BYTE_READ=0x00, BYTE_ERROR_CODE=10.
- Send start plus 4 data bits, then stall 60000 cycles -> TIMEOUT pulse, no BYTE_READY, BYTE_READ unchanged. A following full frame 0xAA is received cleanly.
- Drop READ_ENABLE after bit 3 of 0x55 -> no strobes. RESET mid-frame -> outputs return to reset values. The next frame 0x08 is received with BYTE_ERROR_CODE=00.
- With PS2_GLITCH_FILTER_EN, inject 3-cycle low glitches on CLK_MOUSE_IN during frame 0xF4 -> BYTE_READ=0xF4, no errors. Without the macro, the same stimulus corrupts or misaligns the frame.
